// File: rtl/fixed_power.sv
// Iterative unsigned Q10.10 power unit: out_data = in_data_1 ^ in_data_2 (exponent 0..7).
// One shared multiplier, one multiply per cycle, saturating with early exit on overflow.
module fixed_power #(
  parameter int unsigned   DW   = 20,
  parameter int unsigned   FRAC = 10,
  parameter logic [DW-1:0] ONE  = 20'h00400
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data_1,
  input  logic [2:0]    in_data_2,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          overflow
);

  typedef enum logic {StIdle, StMul} state_e;

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [DW-1:0]   base_q, base_d;
  logic [2:0]      exp_q, exp_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            overflow_q, overflow_d;

  logic [2*DW-1:0] prod;
  logic [2*DW-1:0] next_full;
  logic [DW-1:0]   next;
  logic            sat;

  assign prod      = (2*DW)'(acc_q) * (2*DW)'(base_q);
  assign next_full = prod >> FRAC;
  assign next      = next_full[DW-1:0];
  assign sat       = |next_full[2*DW-1:DW];

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    base_d      = base_q;
    exp_d       = exp_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          // Exponent 0/1 requests finish one cycle after acceptance without multiplying.
          pend_d      = 1'b0;
          out_valid_d = 1'b1;
          overflow_d  = 1'b0;
          out_data_d  = (exp_q == 3'd0) ? ONE : base_q;
        end else if (in_valid) begin
          base_d = in_data_1;
          exp_d  = in_data_2;
          if (in_data_2 >= 3'd2) begin
            acc_d   = in_data_1;
            cnt_d   = 3'd1;
            state_d = StMul;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      StMul: begin
        if (sat) begin
          out_data_d  = '1;
          overflow_d  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          acc_d = next;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q + 3'd1 == exp_q) begin
            out_data_d  = next;
            overflow_d  = 1'b0;
            out_valid_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      base_q      <= '0;
      exp_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q == StMul) || pend_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fixed_power.sv
// Self-checking bench for fixed_power: table vectors plus random model vectors feed a
// scoreboard; a negedge monitor checks data, overflow and latency of every result.
module tb_fixed_power;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] in_data_1;
  logic [2:0]  in_data_2;
  logic        busy;
  logic        out_valid;
  logic [19:0] out_data;
  logic        overflow;

  fixed_power dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] base;
    logic [2:0]  e;
    logic [19:0] data;
    logic        ovf;
    int          lat;
  } vec_t;

  typedef struct {
    logic [19:0] data;
    logic        ovf;
    int          lat;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("out_data", 32'(out_data), 32'(x.data));
        check("overflow", 32'(overflow), 32'(x.ovf));
        check("latency", 32'(cyc - x.e0), 32'(x.lat));
      end
    end
  end

  // Reference behaviour from the arithmetic definition.
  function automatic vec_t model(input logic [19:0] base, input logic [2:0] e);
    vec_t   v;
    longint acc;
    v.base = base; v.e = e; v.ovf = 1'b0;
    v.lat  = (e < 2) ? 1 : int'(e) - 1;
    if (e == 0) begin
      v.data = 20'h00400;
      return v;
    end
    acc = longint'(base);
    for (int i = 1; i < int'(e); i++) begin
      acc = (acc * longint'(base)) >>> 10;
      if (acc > 64'hFFFFF) begin
        v.data = 20'hFFFFF; v.ovf = 1'b1; v.lat = i;
        return v;
      end
    end
    v.data = acc[19:0];
    return v;
  endfunction

  task automatic issue(input vec_t v);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = v.base;
    in_data_2 = v.e;
    sb.push_back('{data: v.data, ovf: v.ovf, lat: v.lat, e0: cyc + 1});
    @(negedge clk);
    in_valid  = 1'b0;
    in_data_1 = 20'($urandom);
    in_data_2 = 3'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{20'h00800, 3'd3, 20'h02000, 1'b0, 2};
    tbl[1]  = '{20'h00600, 3'd3, 20'h00D80, 1'b0, 2};
    tbl[2]  = '{20'h00401, 3'd2, 20'h00402, 1'b0, 1};
    tbl[3]  = '{20'h12345, 3'd0, 20'h00400, 1'b0, 1};
    tbl[4]  = '{20'h12345, 3'd1, 20'h12345, 1'b0, 1};
    tbl[5]  = '{20'h0C800, 3'd4, 20'hFFFFF, 1'b1, 1};
    tbl[6]  = '{20'h00800, 3'd7, 20'h20000, 1'b0, 6};
    tbl[7]  = '{20'h00000, 3'd0, 20'h00400, 1'b0, 1};
    tbl[8]  = '{20'h00000, 3'd5, 20'h00000, 1'b0, 4};
    tbl[9]  = '{20'hFFFFF, 3'd1, 20'hFFFFF, 1'b0, 1};
    tbl[10] = '{20'hFFFFF, 3'd2, 20'hFFFFF, 1'b1, 1};
    tbl[11] = '{20'h00400, 3'd7, 20'h00400, 1'b0, 6};
    tbl[12] = '{20'h04000, 3'd5, 20'hFFFFF, 1'b1, 2};

    rst_n = 1'b0; in_valid = 1'b0; in_data_1 = '0; in_data_2 = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      issue(tbl[i]);
      drain(20);
    end

    for (int i = 0; i < 16; i++) begin
      issue(model(20'($urandom_range(0, 20'h01C00)), 3'($urandom_range(0, 7))));
      drain(20);
    end

    // Requests while busy are dropped.
    issue(tbl[6]);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data_1 = 20'h00600; in_data_2 = 3'd2;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
    end
    drain(20);

    // Back-to-back: new request in the out_valid cycle.
    begin
      int n = 0;
      issue(tbl[0]);
      while (out_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_out_valid_seen", 32'(out_valid), 32'd1);
      check("b2b_busy_low", 32'(busy), 32'd0);
      in_valid = 1'b1; in_data_1 = 20'h00600; in_data_2 = 3'd3;
      sb.push_back('{data: 20'h00D80, ovf: 1'b0, lat: 2, e0: cyc + 1});
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_busy_high", 32'(busy), 32'd1);
      drain(20);
    end

    // Asynchronous reset mid-MUL aborts without a result.
    issue(tbl[6]);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_data", 32'(out_data), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(tbl[1]);
    drain(20);
    issue(tbl[5]);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fixed_power.md
Name: fixed_power

Overview:
- Iterative Q10.10 fixed-point power unit: computes out_data = in_data_1 ^ in_data_2 for an unsigned Q10.10 base and a 3-bit integer exponent.
- Forward (inverse) counterpart of the root engine. Used to generate reference results for the root engine, and as the power step in host-side verification of root outputs.
- Uses one 20x20 multiplier, time-multiplexed over exponent-1 cycles, with saturation and early termination on overflow.

Parameters:
- DW, 20, total data width (Q10.10).
- FRAC, 10, fractional bits; products are shifted right by FRAC after each multiply.
- ONE, 20'h00400, Q10.10 encoding of 1.0, returned for exponent 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  one-cycle request strobe; operands sampled with it.
- in_data_1  input  20  base, unsigned Q10.10.
- in_data_2  input  3  exponent, unsigned integer 0..7.
- busy  output  1  high while a request is in progress; in_valid ignored while high.
- out_valid  output  1  one-cycle result strobe.
- out_data  output  20  result, unsigned Q10.10; held until next result or reset.
- overflow  output  1  result saturated; valid with out_valid, held with out_data.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is asynchronous and active-low (rst_n).
  - Reset values: all outputs 0, state IDLE, internal acc/base/count registers 0.
  - Reset asserted mid-operation aborts immediately; no out_valid is produced for the aborted request.
- States: IDLE, MUL.
- IDLE, in_valid sampled high at edge E0:
  - Latch base_r = in_data_1 and exp_r = in_data_2.
  - exp_r 0: at E1 out_data = ONE, overflow = 0, out_valid = 1; stay IDLE (busy high for the E0..E1 cycle).
  - exp_r 1: at E1 out_data = base, overflow = 0, out_valid = 1.
  - exp_r >= 2: acc = base, count = 1, go to MUL, busy = 1.
- MUL, one multiply per cycle:
  - prod = acc * base_r, 40-bit. next = prod >> FRAC, truncating toward zero; no rounding.
  - next > 20'hFFFFF: saturate. out_data = 20'hFFFFF, overflow = 1, out_valid = 1, return to IDLE. This terminates early, regardless of remaining count.
  - Otherwise acc = next[19:0] and count increments.
  - When count + 1 == exp_r, that edge also drives out_data = next, overflow = 0, out_valid = 1, and returns to IDLE.
- Latency, E0 to the out_valid edge:
  - 1 cycle for exponent 0, 1 or 2.
  - exponent-1 cycles for exponent >= 2.
  - Shorter on overflow.
- out_valid is high for exactly one cycle per accepted request. busy deasserts on the same edge that raises out_valid.
- Back-to-back: in_valid in the cycle where out_valid is high is accepted, because the state is already IDLE.
- in_valid while busy: dropped, with no effect on the ongoing computation.
- Base 0: result 0 for exponent >= 1; ONE for exponent 0.
- in_data_1 and in_data_2 need not be held after E0.

Test Plan:
- Base 0x00800 (2.0), exp 3 -> out_valid 2 cycles after E0, out_data 0x02000, overflow 0.
- Base 0x00600 (1.5), exp 3 -> out_data 0x00D80 (3.375). Base 0x00401, exp 2 -> 0x00402 (truncation check).
- Exp 0 with base 0x12345 -> 0x00400 after 1 cycle. Exp 1 with base 0x12345 -> 0x12345 after 1 cycle.
- Base 0x0C800 (50.0), exp 4 -> overflow at the first multiply: out_valid 1 cycle after E0, out_data 0xFFFFF, overflow 1. Base 0x00800, exp 7 -> 0x20000 after 6 cycles, no overflow.
- in_valid pulses during busy are ignored, and the result is unchanged. A new request in the out_valid cycle is accepted and completes normally.
- rst_n pulsed low mid-MUL -> outputs 0 immediately, no out_valid. The next request after reset release computes correctly.
